// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector-side benches.
// State encodings are fixed because they are exposed on the debug state port.
package seq_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_LOAD  = 3'b001,
      ST_SHIFT = 3'b010,
      ST_DONE  = 3'b100
   } state_e;

   localparam int unsigned SEQ_GEN_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_gen_if.sv
// Control/data bundle between a pattern source (master) and the transmitter (slave).
interface seq_gen_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LW    = $clog2(WIDTH + 1)
);

   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [LW-1:0]    len;
   logic             repeat_en;
   logic             stop;
   logic             dout;
   logic             valid;
   logic             busy;
   logic             done;
   logic [2:0]       state;
   logic [LW-1:0]    ptr;

   modport master (
      output start, pattern, len, repeat_en, stop,
      input  dout, valid, busy, done, state, ptr
   );

   modport slave (
      input  start, pattern, len, repeat_en, stop,
      output dout, valid, busy, done, state, ptr
   );

endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: latches a parallel pattern and shifts it out MSB-first,
// one bit per clock, optionally wrapping back to bit 0 with no gap.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned WIDTH = SEQ_GEN_DEFAULT_WIDTH
) (
   input logic     clk,
   input logic     rst,
   seq_gen_if.slave bus
);

   localparam int unsigned LW = $clog2(WIDTH + 1);

   state_e           state_q,   state_d;
   logic [WIDTH-1:0] shreg_q,   shreg_d;
   logic [WIDTH-1:0] copy_q,    copy_d;
   logic [LW-1:0]    eff_len_q, eff_len_d;
   logic [LW-1:0]    ptr_q,     ptr_d;
   logic             dout_q,    dout_d;
   logic             valid_q,   valid_d;
   logic             done_q,    done_d;
   logic             last_bit;

   assign last_bit = (ptr_q == eff_len_q - LW'(1));

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      copy_d    = copy_q;
      eff_len_d = eff_len_q;
      ptr_d     = ptr_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               shreg_d = bus.pattern;
               copy_d  = bus.pattern;
               if (bus.len == '0 || bus.len > LW'(WIDTH)) begin
                  eff_len_d = LW'(WIDTH);
               end else begin
                  eff_len_d = bus.len;
               end
            end
         end

         ST_LOAD: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               dout_d  = 1'b0;
               valid_d = 1'b0;
               ptr_d   = '0;
            end else begin
               state_d = ST_SHIFT;
               dout_d  = shreg_q[WIDTH-1];
               shreg_d = shreg_q << 1;
               valid_d = 1'b1;
               ptr_d   = '0;
            end
         end

         ST_SHIFT: begin
            // shreg already holds the bit after the one on dout, so a plain shift
            // and a wrap reload both take one edge and leave no gap in valid.
            if (bus.stop) begin
               state_d = ST_IDLE;
               dout_d  = 1'b0;
               valid_d = 1'b0;
               ptr_d   = '0;
            end else if (!last_bit) begin
               dout_d  = shreg_q[WIDTH-1];
               shreg_d = shreg_q << 1;
               ptr_d   = ptr_q + LW'(1);
            end else if (bus.repeat_en) begin
               dout_d  = copy_q[WIDTH-1];
               shreg_d = copy_q << 1;
               ptr_d   = '0;
            end else begin
               state_d = ST_DONE;
               dout_d  = 1'b0;
               valid_d = 1'b0;
               done_d  = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end

         default: begin
            state_d = ST_IDLE;
            dout_d  = 1'b0;
            valid_d = 1'b0;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         copy_q    <= '0;
         eff_len_q <= '0;
         ptr_q     <= '0;
         dout_q    <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         copy_q    <= copy_d;
         eff_len_q <= eff_len_d;
         ptr_q     <= ptr_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.valid = valid_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q != ST_IDLE);
   assign bus.state = state_q;
   assign bus.ptr   = ptr_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: each task drives one scenario and checks outputs inline.
module tb_seq_gen;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned LW    = $clog2(WIDTH + 1);

   logic clk;
   logic rst;
   int   total;
   int   bad;

   seq_gen_if #(.WIDTH(WIDTH)) bus ();

   seq_gen #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      total++;
      if (bus.state !== 3'b000 || bus.valid !== 1'b0 || bus.dout !== 1'b0 ||
          bus.ptr !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: state=%b valid=%b dout=%b ptr=%0d done=%b busy=%b want idle/0s",
                  name, bus.state, bus.valid, bus.dout, bus.ptr, bus.done, bus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_idle("reset");
      rst = 1'b0;
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check_idle("stop_in_idle");
   endtask

   task automatic test_single_frame();
      logic [7:0] exp;
      exp = 8'hA5;
      bus.pattern = 32'hA500_0000;
      bus.len = LW'(8);
      bus.repeat_en = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      total++;
      if (bus.state !== 3'b001 || bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL load_state: state=%b valid=%b busy=%b want 001/0/1", bus.state, bus.valid, bus.busy);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== exp[7-i] || bus.ptr !== LW'(i) || bus.state !== 3'b010) begin
            bad++;
            $display("FAIL single_bit%0d: valid=%b dout=%b ptr=%0d state=%b want 1/%b/%0d/010",
                     i, bus.valid, bus.dout, bus.ptr, bus.state, exp[7-i], i);
         end
         tick();
      end
      total++;
      if (bus.done !== 1'b1 || bus.state !== 3'b100 || bus.valid !== 1'b0 || bus.dout !== 1'b0) begin
         bad++;
         $display("FAIL single_done: done=%b state=%b valid=%b dout=%b want 1/100/0/0",
                  bus.done, bus.state, bus.valid, bus.dout);
      end
      tick();
      check_idle("single_after_done");
   endtask

   task automatic test_repeat_stop();
      bus.pattern = 32'hC000_0000;
      bus.len = LW'(3);
      bus.repeat_en = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int k = 0; k < 9; k++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== ((k % 3) != 2) || bus.ptr !== LW'(k % 3)) begin
            bad++;
            $display("FAIL repeat_k%0d: valid=%b dout=%b ptr=%0d want 1/%b/%0d",
                     k, bus.valid, bus.dout, bus.ptr, ((k % 3) != 2), k % 3);
         end
         tick();
      end
      tick();
      total++;
      if (bus.ptr !== LW'(1) || bus.dout !== 1'b1 || bus.valid !== 1'b1) begin
         bad++;
         $display("FAIL repeat_pre_stop: ptr=%0d dout=%b valid=%b want 1/1/1", bus.ptr, bus.dout, bus.valid);
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.repeat_en = 1'b0;
      check_idle("repeat_stopped");
      tick();
      check_idle("repeat_no_done");
   endtask

   task automatic test_full(input logic [LW-1:0] l, input string name);
      bus.pattern = 32'h8000_0001;
      bus.len = l;
      bus.repeat_en = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int i = 0; i < 32; i++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== (i == 0 || i == 31) || bus.ptr !== LW'(i)) begin
            bad++;
            $display("FAIL %s_bit%0d: valid=%b dout=%b ptr=%0d want 1/%b/%0d",
                     name, i, bus.valid, bus.dout, bus.ptr, (i == 0 || i == 31), i);
         end
         tick();
      end
      total++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
         bad++;
         $display("FAIL %s_done: done=%b valid=%b want 1/0", name, bus.done, bus.valid);
      end
      tick();
      check_idle({name, "_idle"});
   endtask

   task automatic test_start_ignored();
      logic [3:0] exp;
      exp = 4'b1001;
      bus.pattern = 32'h9000_0000;
      bus.len = LW'(4);
      bus.repeat_en = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== exp[3-i] || bus.ptr !== LW'(i)) begin
            bad++;
            $display("FAIL ignore_bit%0d: valid=%b dout=%b ptr=%0d want 1/%b/%0d",
                     i, bus.valid, bus.dout, bus.ptr, exp[3-i], i);
         end
         if (i == 1) begin
            bus.start = 1'b1;
            bus.pattern = 32'hFFFF_FFFF;
            bus.len = LW'(2);
         end
         tick();
         bus.start = 1'b0;
      end
      total++;
      if (bus.done !== 1'b1 || bus.state !== 3'b100) begin
         bad++;
         $display("FAIL ignore_done: done=%b state=%b want 1/100", bus.done, bus.state);
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_idle("ignore_start_in_done");
      tick();
      check_idle("ignore_stays_idle");
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp;
      exp = 8'hA5;
      bus.pattern = 32'hA500_0000;
      bus.len = LW'(8);
      bus.repeat_en = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (bus.ptr !== LW'(5) || bus.valid !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_ptr: ptr=%0d valid=%b want 5/1", bus.ptr, bus.valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rstmid_reset");
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== exp[7-i] || bus.ptr !== LW'(i)) begin
            bad++;
            $display("FAIL rstmid_bit%0d: valid=%b dout=%b ptr=%0d want 1/%b/%0d",
                     i, bus.valid, bus.dout, bus.ptr, exp[7-i], i);
         end
         tick();
      end
      total++;
      if (bus.done !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_done: done=%b want 1", bus.done);
      end
      tick();
   endtask

   task automatic test_repeat_clear();
      logic [3:0] exp;
      exp = 4'b1011;
      bus.pattern = 32'hB000_0000;
      bus.len = LW'(4);
      bus.repeat_en = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== exp[3-(k%4)] || bus.ptr !== LW'(k % 4)) begin
            bad++;
            $display("FAIL rclr_k%0d: valid=%b dout=%b ptr=%0d want 1/%b/%0d",
                     k, bus.valid, bus.dout, bus.ptr, exp[3-(k%4)], k % 4);
         end
         if (k == 5) bus.repeat_en = 1'b0;
         tick();
      end
      total++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.state !== 3'b100) begin
         bad++;
         $display("FAIL rclr_done: done=%b valid=%b state=%b want 1/0/100", bus.done, bus.valid, bus.state);
      end
      tick();
      check_idle("rclr_idle");
   endtask

   task automatic test_len_one();
      bus.pattern = 32'h8000_0000;
      bus.len = LW'(1);
      bus.repeat_en = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         total++;
         if (bus.valid !== 1'b1 || bus.dout !== 1'b1 || bus.ptr !== '0) begin
            bad++;
            $display("FAIL len1_k%0d: valid=%b dout=%b ptr=%0d want 1/1/0", k, bus.valid, bus.dout, bus.ptr);
         end
         tick();
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.repeat_en = 1'b0;
      check_idle("len1_stop_beats_wrap");
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.pattern = '0;
      bus.len = '0;
      bus.repeat_en = 1'b0;
      bus.stop = 1'b0;
      test_reset();
      test_single_frame();
      test_repeat_stop();
      test_full(LW'(0), "full_len0");
      test_full(LW'(40), "full_len40");
      test_start_ignored();
      test_reset_mid();
      test_repeat_clear();
      test_len_one();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
